// File: rtl/gmii_rx_frame_checker.sv
// Per-port GMII receive frame checker: delineates preamble/SFD, counts length,
// checks the FCS residue and timestamps the SFD, emitting one report per frame.
module gmii_rx_frame_checker #(
    parameter int TS_WIDTH = 32,
    parameter int MIN_LEN  = 64,
    parameter int MAX_LEN  = 1518
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          gmii_rxd_reg,
    input  logic                gmii_rx_dv_reg,
    input  logic                gmii_rx_er_reg,
    output logic                frame_valid,
    output logic [10:0]         frame_len,
    output logic [TS_WIDTH-1:0] frame_ts,
    output logic                crc_ok,
    output logic                len_err,
    output logic                rx_err,
    output logic [15:0]         drop_cnt
);
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0] LEN_MIN     = 11'(MIN_LEN);
    localparam logic [10:0] LEN_MAX     = 11'(MAX_LEN);
    localparam logic [10:0] LEN_SAT     = 11'h7FF;

    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

    state_t                state_q, state_d;
    logic                  sfd_hit, data_byte, report, drop_hit;
    logic [TS_WIDTH-1:0]   ts, ts_lat;
    logic [10:0]           len_cnt;
    logic [31:0]           crc;
    logic                  err_flag;

    // Reflected CRC-32, one byte per call, LSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++)
            c = (c[0] ^ d[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        return c;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        sfd_hit   = 1'b0;
        data_byte = 1'b0;
        report    = 1'b0;
        drop_hit  = 1'b0;
        case (state_q)
            IDLE: if (gmii_rx_dv_reg) state_d = (gmii_rxd_reg == 8'h55) ? PRE : DROP;
            PRE: begin
                if (!gmii_rx_dv_reg) begin
                    state_d  = IDLE;
                    drop_hit = 1'b1;
                end else if (gmii_rxd_reg == 8'hD5) begin
                    state_d = DATA;
                    sfd_hit = 1'b1;
                end else if (gmii_rxd_reg != 8'h55) begin
                    state_d = DROP;
                end
            end
            DATA: begin
                if (gmii_rx_dv_reg) begin
                    data_byte = 1'b1;
                end else begin
                    state_d = IDLE;
                    report  = 1'b1;
                end
            end
            DROP: begin
                if (!gmii_rx_dv_reg) begin
                    state_d  = IDLE;
                    drop_hit = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts          <= '0;
            ts_lat      <= '0;
            len_cnt     <= '0;
            crc         <= '0;
            err_flag    <= 1'b0;
            frame_valid <= 1'b0;
            frame_len   <= '0;
            frame_ts    <= '0;
            crc_ok      <= 1'b0;
            len_err     <= 1'b0;
            rx_err      <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            ts          <= ts + 1'b1;
            frame_valid <= report;
            if (sfd_hit) begin
                ts_lat   <= ts;
                len_cnt  <= '0;
                crc      <= 32'hFFFFFFFF;
                err_flag <= 1'b0;
            end
            if (data_byte) begin
                if (len_cnt != LEN_SAT) len_cnt <= len_cnt + 11'd1;
                crc <= crc32_byte(crc, gmii_rxd_reg);
                if (gmii_rx_er_reg) err_flag <= 1'b1;
            end
            // An empty data phase leaves crc at all-ones, so it never matches.
            if (report) begin
                frame_len <= len_cnt;
                frame_ts  <= ts_lat;
                crc_ok    <= (crc == CRC_RESIDUE);
                len_err   <= (len_cnt < LEN_MIN) || (len_cnt > LEN_MAX);
                rx_err    <= err_flag;
            end
            if (drop_hit && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_gmii_rx_frame_checker.sv
// Directed bench for gmii_rx_frame_checker: table of frames plus hand-written
// preamble-abort, back-to-back and mid-frame reset sequences.
module tb_gmii_rx_frame_checker;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  gmii_rxd_reg;
    logic        gmii_rx_dv_reg;
    logic        gmii_rx_er_reg;
    logic        frame_valid;
    logic [10:0] frame_len;
    logic [31:0] frame_ts;
    logic        crc_ok, len_err, rx_err;
    logic [15:0] drop_cnt;

    gmii_rx_frame_checker #(.TS_WIDTH(32), .MIN_LEN(64), .MAX_LEN(1518)) dut (
        .clk(clk), .reset(reset),
        .gmii_rxd_reg(gmii_rxd_reg), .gmii_rx_dv_reg(gmii_rx_dv_reg), .gmii_rx_er_reg(gmii_rx_er_reg),
        .frame_valid(frame_valid), .frame_len(frame_len), .frame_ts(frame_ts),
        .crc_ok(crc_ok), .len_err(len_err), .rx_err(rx_err), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int tb_cyc;
    int rep_cnt = 0;
    int log_len [0:63];
    int log_ts  [0:63];
    bit log_crc [0:63];
    bit log_ler [0:63];
    bit log_rxe [0:63];
    logic [7:0] fbuf [0:2199];
    int exp_ts;

    // Cycle index since reset release: the expected timestamp source.
    always @(posedge clk or posedge reset)
        if (reset) tb_cyc <= 0;
        else       tb_cyc <= tb_cyc + 1;

    // Record every report pulse (sampled before the edge updates the DUT).
    always @(posedge clk)
        if (!reset && frame_valid) begin
            log_len[rep_cnt % 64] <= int'(frame_len);
            log_ts [rep_cnt % 64] <= int'(frame_ts);
            log_crc[rep_cnt % 64] <= crc_ok;
            log_ler[rep_cnt % 64] <= len_err;
            log_rxe[rep_cnt % 64] <= rx_err;
            rep_cnt <= rep_cnt + 1;
        end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act !== exp) $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        else pass_cnt++;
    endtask

    function automatic logic [31:0] crc_model(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in;
        for (int b = 0; b < 8; b++) begin
            if (c[0] ^ d[b]) c = (c >> 1) ^ 32'hEDB88320;
            else             c = c >> 1;
        end
        return c;
    endfunction

    // Inputs change on the falling edge; the DUT samples them on the next rising edge.
    task automatic cyc(input logic dv, input logic [7:0] d, input logic er);
        gmii_rx_dv_reg = dv;
        gmii_rxd_reg   = d;
        gmii_rx_er_reg = er;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
    endtask

    // Send one frame of ndata bytes plus FCS; leaves exp_ts set to the SFD cycle.
    task automatic send_frame(input int ndata, input int pat, input int corrupt, input int er_idx);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < ndata; i++) begin
            fbuf[i] = (pat == 0) ? 8'h00 : 8'((i * pat + 3) & 255);
            c = crc_model(c, fbuf[i]);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) fbuf[ndata + k] = c[8*k +: 8];
        if (corrupt >= 0) fbuf[corrupt] = fbuf[corrupt] ^ 8'h01;
        for (int i = 0; i < 7; i++) cyc(1'b1, 8'h55, 1'b0);
        exp_ts = tb_cyc;
        cyc(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < ndata + 4; i++) cyc(1'b1, fbuf[i], (i == er_idx));
        cyc(1'b0, 8'h00, 1'b0);
        chk("report_pulse", {31'd0, frame_valid}, 32'd1);
    endtask

    task automatic chk_report(input string tag, input int idx, input int e_len, input int e_ts,
                              input bit e_crc, input bit e_ler, input bit e_rxe);
        chk({tag, ".len"},     log_len[idx % 64], e_len);
        chk({tag, ".ts"},      log_ts[idx % 64], e_ts);
        chk({tag, ".crc_ok"},  {31'd0, log_crc[idx % 64]}, {31'd0, e_crc});
        chk({tag, ".len_err"}, {31'd0, log_ler[idx % 64]}, {31'd0, e_ler});
        chk({tag, ".rx_err"},  {31'd0, log_rxe[idx % 64]}, {31'd0, e_rxe});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".valid"},  {31'd0, frame_valid}, 32'd0);
        chk({tag, ".len"},    {21'd0, frame_len}, 32'd0);
        chk({tag, ".ts"},     frame_ts, 32'd0);
        chk({tag, ".flags"},  {29'd0, crc_ok, len_err, rx_err}, 32'd0);
        chk({tag, ".drop"},   {16'd0, drop_cnt}, 32'd0);
    endtask

    typedef struct {
        int ndata; int pat; int corrupt; int er_idx;
        int exp_len; bit exp_crc; bit exp_ler; bit exp_rxe;
    } vec_t;

    vec_t vecs [0:8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, ts_a, ts_b;
        vecs[0] = '{60,   0,  -1, -1,   64, 1'b1, 1'b0, 1'b0};  // good frame
        vecs[1] = '{60,   0,  10, -1,   64, 1'b0, 1'b0, 1'b0};  // byte 10 flipped
        vecs[2] = '{16,   5,  -1, -1,   20, 1'b1, 1'b1, 1'b0};  // runt
        vecs[3] = '{1596, 7,  -1, -1, 1600, 1'b1, 1'b1, 1'b0};  // oversize
        vecs[4] = '{60,   0,  -1, 30,   64, 1'b1, 1'b0, 1'b1};  // er on data byte
        vecs[5] = '{1514, 3,  -1, -1, 1518, 1'b1, 1'b0, 1'b0};  // max legal
        vecs[6] = '{59,   9,  -1, -1,   63, 1'b1, 1'b1, 1'b0};  // one short
        vecs[7] = '{1515, 11, -1, -1, 1519, 1'b1, 1'b1, 1'b0};  // one over
        vecs[8] = '{2096, 13, -1, -1, 2047, 1'b1, 1'b1, 1'b0};  // length saturates

        reset = 1'b1;
        gmii_rxd_reg = 8'h00; gmii_rx_dv_reg = 1'b0; gmii_rx_er_reg = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("in_reset");
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("after_reset");

        // Preamble aborts
        r0 = rep_cnt;
        cyc(1'b1, 8'h55, 1'b0); cyc(1'b1, 8'h55, 1'b0); cyc(1'b1, 8'h12, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'hD5, 1'b0);
        idle(3);
        chk("abort1.drop", {16'd0, drop_cnt}, 32'd1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h55, 1'b0);
        idle(3);
        chk("abort2.drop", {16'd0, drop_cnt}, 32'd2);
        cyc(1'b1, 8'hD5, 1'b0); cyc(1'b1, 8'h55, 1'b0); cyc(1'b1, 8'h55, 1'b0);
        idle(3);
        chk("abort3.drop", {16'd0, drop_cnt}, 32'd3);
        chk("abort.no_report", rep_cnt, r0);

        // Table of frames
        for (int v = 0; v < 9; v++) begin
            r0 = rep_cnt;
            send_frame(vecs[v].ndata, vecs[v].pat, vecs[v].corrupt, vecs[v].er_idx);
            idle(2);
            chk($sformatf("vec%0d.count", v), rep_cnt, r0 + 1);
            chk_report($sformatf("vec%0d", v), r0, vecs[v].exp_len, exp_ts,
                       vecs[v].exp_crc, vecs[v].exp_ler, vecs[v].exp_rxe);
        end
        chk("table.drop_unchanged", {16'd0, drop_cnt}, 32'd3);

        // er without dv is ignored, then a good frame follows
        r0 = rep_cnt;
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'hAA, 1'b1);
        chk("idle_er.no_report", rep_cnt, r0);
        send_frame(60, 0, -1, -1);
        idle(2);
        chk("idle_er.count", rep_cnt, r0 + 1);
        chk_report("idle_er", r0, 64, exp_ts, 1'b1, 1'b0, 1'b0);

        // Back-to-back with a single-cycle gap
        r0 = rep_cnt;
        send_frame(60, 0, -1, -1);
        ts_a = exp_ts;
        send_frame(70, 21, -1, -1);
        ts_b = exp_ts;
        idle(2);
        chk("b2b.count", rep_cnt, r0 + 2);
        chk_report("b2b0", r0, 64, ts_a, 1'b1, 1'b0, 1'b0);
        chk_report("b2b1", r0 + 1, 74, ts_b, 1'b1, 1'b0, 1'b0);

        // Reset mid-DATA
        r0 = rep_cnt;
        for (int i = 0; i < 7; i++) cyc(1'b1, 8'h55, 1'b0);
        cyc(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 8'h33, 1'b0);
        reset = 1'b1;
        gmii_rx_dv_reg = 1'b0;
        @(negedge clk);
        chk_all_zero("mid_reset");
        reset = 1'b0;
        idle(3);
        chk_all_zero("post_reset");
        chk("mid_reset.no_report", rep_cnt, r0);
        send_frame(60, 0, -1, -1);
        idle(2);
        chk("post_reset.count", rep_cnt, r0 + 1);
        chk_report("post_reset", r0, 64, exp_ts, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
